// File: rtl/mem_access.sv
// Memory-access stage: registers ALU results through to writeback and runs
// single outstanding load/store transactions against the data memory.
module mem_access #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              wb_en_i,
  input  logic [3:0]        rd_addr_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic [DATA_W-1:0] st_data_i,
  input  logic              ctrl_ld_i,
  input  logic              ctrl_st_i,
  output logic              stall_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_ready_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  input  logic              dmem_rvalid_i,
  output logic              wb_en_o,
  output logic [3:0]        rd_addr_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              err_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } dmem_req_t;

  typedef struct packed {
    logic              en;
    logic [3:0]        rd;
    logic [DATA_W-1:0] data;
  } wb_t;

  state_t     state_q, state_d;
  dmem_req_t  mreq_q, mreq_d;
  wb_t        wb_q, wb_d;
  logic [3:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       expire;
  logic       unused_hi;

  assign unused_hi = ^result_i[DATA_W-1:ADDR_W];

  // Watchdog fires on the edge that would bring the count to TIMEOUT.
  assign expire = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    mreq_d  = mreq_q;
    wb_d    = wb_q;
    wb_d.en = 1'b0;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (ctrl_ld_i || ctrl_st_i) begin
            rd_d         = rd_addr_i;
            mreq_d.req   = 1'b1;
            mreq_d.we    = ctrl_st_i & ~ctrl_ld_i;
            mreq_d.addr  = result_i[ADDR_W-1:0];
            mreq_d.wdata = st_data_i;
            cnt_d        = '0;
            state_d      = REQ;
          end else begin
            wb_d.en   = wb_en_i;
            wb_d.rd   = rd_addr_i;
            wb_d.data = result_i;
          end
        end
      end
      REQ: begin
        if (dmem_ready_i) begin
          mreq_d.req = 1'b0;
          mreq_d.we  = 1'b0;
          cnt_d      = '0;
          state_d    = mreq_q.we ? IDLE : RESP;
        end else if (expire) begin
          mreq_d.req = 1'b0;
          mreq_d.we  = 1'b0;
          err_d      = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (dmem_rvalid_i) begin
          wb_d.en   = 1'b1;
          wb_d.rd   = rd_q;
          wb_d.data = dmem_rdata_i;
          state_d   = IDLE;
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mreq_q  <= '0;
      wb_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mreq_q  <= mreq_d;
      wb_q    <= wb_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign stall_o      = (state_q != IDLE);
  assign dmem_req_o   = mreq_q.req;
  assign dmem_we_o    = mreq_q.we;
  assign dmem_addr_o  = mreq_q.addr;
  assign dmem_wdata_o = mreq_q.wdata;
  assign wb_en_o      = wb_q.en;
  assign rd_addr_o    = wb_q.rd;
  assign wb_data_o    = wb_q.data;
  assign err_o        = err_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed scenarios then random ALU/ld/st traffic with
// random memory wait states, checked against a transaction-level model.
module tb_mem_access;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, wb_en_i, ctrl_ld_i, ctrl_st_i;
  logic [3:0]  rd_addr_i;
  logic [31:0] result_i, st_data_i;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [15:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ready_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_en_o, err_o;
  logic [3:0]  rd_addr_o;
  logic [31:0] wb_data_o;

  int total = 0;
  int bad = 0;
  bit err_exp = 1'b0;
  logic [31:0] mem [logic [15:0]];

  mem_access #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .wb_en_i(wb_en_i),
    .rd_addr_i(rd_addr_i), .result_i(result_i), .st_data_i(st_data_i),
    .ctrl_ld_i(ctrl_ld_i), .ctrl_st_i(ctrl_st_i), .stall_o(stall_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_ready_i(dmem_ready_i),
    .dmem_rdata_i(dmem_rdata_i), .dmem_rvalid_i(dmem_rvalid_i),
    .wb_en_o(wb_en_o), .rd_addr_o(rd_addr_o), .wb_data_o(wb_data_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stall"}, stall_o, 0);
    chk({tag, "_req"},   dmem_req_o, 0);
    chk({tag, "_we"},    dmem_we_o, 0);
    chk({tag, "_addr"},  dmem_addr_o, 0);
    chk({tag, "_wdata"}, dmem_wdata_o, 0);
    chk({tag, "_wben"},  wb_en_o, 0);
    chk({tag, "_rd"},    rd_addr_o, 0);
    chk({tag, "_data"},  wb_data_o, 0);
    chk({tag, "_err"},   err_o, 0);
  endtask

  // ALU op: result must appear exactly one cycle later; leaves valid_i high.
  task automatic alu(input logic wb, input logic [3:0] rd, input logic [31:0] res);
    chk("alu_nostall", stall_o, 0);
    valid_i = 1'b1; ctrl_ld_i = 1'b0; ctrl_st_i = 1'b0;
    wb_en_i = wb; rd_addr_i = rd; result_i = res; st_data_i = $urandom;
    @(negedge clk);
    chk("alu_wben", wb_en_o, wb);
    chk("alu_rd",   rd_addr_o, rd);
    chk("alu_data", wb_data_o, res);
    chk("alu_err",  err_o, err_exp);
  endtask

  task automatic idle();
    valid_i = 1'b0; ctrl_ld_i = 1'b0; ctrl_st_i = 1'b0;
    @(negedge clk);
    chk("idle_wben", wb_en_o, 0);
    chk("idle_stall", stall_o, 0);
  endtask

  // Memory op with w wait cycles before ready and d RESP cycles before rvalid.
  task automatic mem_op(input bit ld, input bit st, input logic [3:0] rd,
                        input logic [31:0] res, input logic [31:0] sdata,
                        input int w, input int d);
    logic [15:0] a;
    logic [31:0] rdv;
    bit exp_we;
    a = res[15:0];
    exp_we = st && !ld;
    valid_i = 1'b1; ctrl_ld_i = ld; ctrl_st_i = st; wb_en_i = $urandom;
    rd_addr_i = rd; result_i = res; st_data_i = sdata;
    for (int k = 0; k <= w && k < TO; k++) begin
      @(negedge clk);
      chk("req_stall", stall_o, 1);
      chk("req_req",   dmem_req_o, 1);
      chk("req_we",    dmem_we_o, exp_we);
      chk("req_addr",  dmem_addr_o, a);
      if (exp_we) chk("req_wdata", dmem_wdata_o, sdata);
      chk("req_nowb",  wb_en_o, 0);
      dmem_ready_i  = (k == w);
      dmem_rvalid_i = $urandom;
      dmem_rdata_i  = $urandom;
    end
    @(negedge clk);
    dmem_ready_i = 1'b0; dmem_rvalid_i = 1'b0;
    if (w >= TO) begin
      err_exp = 1'b1;
      chk("reqto_stall", stall_o, 0);
      chk("reqto_req",   dmem_req_o, 0);
      chk("reqto_wben",  wb_en_o, 0);
      chk("reqto_err",   err_o, 1);
    end else if (exp_we) begin
      mem[a] = sdata;
      chk("st_stall", stall_o, 0);
      chk("st_req",   dmem_req_o, 0);
      chk("st_wben",  wb_en_o, 0);
      chk("st_err",   err_o, err_exp);
    end else begin
      rdv = mem.exists(a) ? mem[a] : $urandom;
      for (int j = 0; j <= d && j < TO; j++) begin
        chk("resp_stall", stall_o, 1);
        chk("resp_req",   dmem_req_o, 0);
        chk("resp_nowb",  wb_en_o, 0);
        dmem_rvalid_i = (j == d);
        dmem_rdata_i  = (j == d) ? rdv : $urandom;
        @(negedge clk);
      end
      dmem_rvalid_i = 1'b0;
      if (d >= TO) begin
        err_exp = 1'b1;
        chk("respto_stall", stall_o, 0);
        chk("respto_wben",  wb_en_o, 0);
        chk("respto_err",   err_o, 1);
      end else begin
        chk("ld_stall", stall_o, 0);
        chk("ld_wben",  wb_en_o, 1);
        chk("ld_rd",    rd_addr_o, rd);
        chk("ld_data",  wb_data_o, rdv);
        chk("ld_err",   err_o, err_exp);
      end
    end
    idle();
  endtask

  initial begin
    rst = 1'b0;
    valid_i = 0; wb_en_i = 0; ctrl_ld_i = 0; ctrl_st_i = 0;
    rd_addr_i = 0; result_i = 0; st_data_i = 0;
    dmem_ready_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
    #12;
    chk_zero("rst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // ALU pass-through, then a back-to-back stream
    alu(1'b1, 4'd5, 32'h1234_5678);
    alu(1'b0, 4'd6, 32'h0000_0001);
    alu(1'b1, 4'd7, 32'hFFFF_FFFF);
    alu(1'b1, 4'd8, 32'hA5A5_5A5A);
    idle();

    // Zero-wait load, store with 3 wait states, ALU again
    mem[16'h00A4] = 32'hDEAD_BEEF;
    mem_op(1'b1, 1'b0, 4'd3, 32'h0000_00A4, 32'h0, 0, 0);
    mem_op(1'b0, 1'b1, 4'd9, 32'h0000_0010, 32'hCAFE_0001, 3, 0);
    mem_op(1'b1, 1'b0, 4'd4, 32'h0000_0010, 32'h0, 1, 2);

    // Handshake on the expiry edge wins, then true timeouts set err
    mem_op(1'b1, 1'b0, 4'd2, 32'h0000_0020, 32'h0, TO - 1, TO - 1);
    chk("edge_noerr", err_o, 0);
    mem_op(1'b1, 1'b0, 4'd7, 32'h0000_0030, 32'h0, 0, 20);
    alu(1'b1, 4'd1, 32'h0BAD_F00D);
    idle();
    mem_op(1'b0, 1'b1, 4'd0, 32'h0000_0040, 32'h1111_2222, TO + 2, 0);

    // Both ld and st: load wins, memory untouched
    mem[16'h0050] = 32'h5555_AAAA;
    mem_op(1'b1, 1'b1, 4'd11, 32'hFFFF_0050, 32'h9999_9999, 1, 1);
    chk("ldst_nowrite", mem[16'h0050], 32'h5555_AAAA);

    // Reset while waiting for load data, then a stray rvalid
    valid_i = 1'b1; ctrl_ld_i = 1'b1; ctrl_st_i = 1'b0;
    rd_addr_i = 4'd12; result_i = 32'h0000_00A4;
    @(negedge clk);
    dmem_ready_i = 1'b1;
    @(negedge clk);
    dmem_ready_i = 1'b0;
    chk("mid_stall", stall_o, 1);
    #2 rst = 1'b0;
    #1 chk_zero("midrst");
    err_exp = 1'b0;
    valid_i = 1'b0; ctrl_ld_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h7777_7777;
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    chk("stray_wben", wb_en_o, 0);
    chk("stray_stall", stall_o, 0);
    idle();

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      int kind, w, d;
      logic [31:0] res;
      kind = $urandom_range(0, 9);
      w = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TO + 2) : $urandom_range(0, 2);
      d = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TO + 2) : $urandom_range(0, 2);
      res = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 7));
      case (kind)
        0, 1, 2, 3: begin
          alu(1'($urandom), 4'($urandom), $urandom);
          if ($urandom_range(0, 1) == 0) idle();
        end
        4, 5, 6: mem_op(1'b1, 1'b0, 4'($urandom), res, $urandom, w, d);
        7, 8:    mem_op(1'b0, 1'b1, 4'($urandom), res, $urandom, w, d);
        default: mem_op(1'b1, 1'b1, 4'($urandom), res, $urandom, w, d);
      endcase
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
